// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver/transmitter FSM encoding and legal oversampling ratios
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter and 3-sample majority voter around mid-bit
module uart_rx_sampler (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       start,
    input  logic       busy,
    input  logic       rx,
    input  logic [5:0] prescale,
    output logic       bit_end,
    output logic       bit_ready,
    output logic       bit_val
);
    logic [5:0] edge_cnt;
    logic [5:0] half;
    logic [2:0] samples;
    logic       sample_now;
    always_comb begin
        half       = {1'b0, prescale[5:1]};
        bit_end    = edge_cnt == prescale - 6'd1;
        bit_ready  = edge_cnt == half + 6'd2;
        sample_now = edge_cnt == half - 6'd1 || edge_cnt == half || edge_cnt == half + 6'd1;
        bit_val    = (samples[0] & samples[1]) | (samples[0] & samples[2]) | (samples[1] & samples[2]);
    end
    // the start-detect cycle is edge 0, so the counter enters the frame at 1
    always_ff @(posedge CLK or negedge Reset)
        if (!Reset) begin
            edge_cnt <= '0;
            samples  <= '0;
        end else begin
            edge_cnt <= start ? 6'd1 : (!busy || bit_end) ? 6'd0 : edge_cnt + 6'd1;
            if (sample_now) samples <= {samples[1:0], rx};
        end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with optional parity and registered status pulses
module uart_rx import uart_pkg::*; #(
    parameter int width = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             RX_IN,
    input  logic [5:0]       Prescale,
    input  logic             Parity_EN,
    input  logic             Parity_type,
    output logic [width-1:0] P_DATA,
    output logic             Data_valid,
    output logic             Parity_error,
    output logic             Stop_error
);
    localparam int BW = width > 1 ? $clog2(width) : 1;
    uart_state_e      state, state_nxt;
    logic [BW-1:0]    bit_cnt;
    logic [5:0]       p_lat;
    logic             par_en, par_odd, par_bad;
    logic [width-1:0] shift;
    logic             start, busy, bit_end, bit_ready, bit_val, last_bit;
    logic             dv_nxt, pe_nxt, se_nxt;
    assign start    = state == IDLE && !RX_IN;
    assign busy     = state != IDLE;
    assign last_bit = bit_cnt == BW'(width - 1);
    uart_rx_sampler u_sampler (
        .CLK       (CLK),
        .Reset     (Reset),
        .start     (start),
        .busy      (busy),
        .rx        (RX_IN),
        .prescale  (p_lat),
        .bit_end   (bit_end),
        .bit_ready (bit_ready),
        .bit_val   (bit_val)
    );
    always_ff @(posedge CLK or negedge Reset)
        if (!Reset) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        dv_nxt    = 1'b0;
        pe_nxt    = 1'b0;
        se_nxt    = 1'b0;
        case (state)
            IDLE:   state_nxt = start ? START : IDLE;
            START:  state_nxt = (bit_ready && bit_val) ? IDLE : bit_end ? DATA : START;
            DATA:   state_nxt = (bit_end && last_bit) ? (par_en ? PARITY : STOP) : DATA;
            PARITY: state_nxt = bit_end ? STOP : PARITY;
            STOP: begin
                state_nxt = bit_end ? IDLE : STOP;
                dv_nxt    = bit_end && !par_bad && bit_val;
                pe_nxt    = bit_end && par_bad;
                se_nxt    = bit_end && !bit_val;
            end
            default: state_nxt = IDLE;
        endcase
    end
    // frame configuration is frozen on the start-detect cycle
    always_ff @(posedge CLK or negedge Reset)
        if (!Reset) begin
            P_DATA       <= '0;
            Data_valid   <= 1'b0;
            Parity_error <= 1'b0;
            Stop_error   <= 1'b0;
            bit_cnt      <= '0;
            p_lat        <= '0;
            par_en       <= 1'b0;
            par_odd      <= 1'b0;
            par_bad      <= 1'b0;
            shift        <= '0;
        end else begin
            Data_valid   <= dv_nxt;
            Parity_error <= pe_nxt;
            Stop_error   <= se_nxt;
            if (dv_nxt) P_DATA <= shift;
            if (start) begin
                p_lat   <= Prescale;
                par_en  <= Parity_EN;
                par_odd <= Parity_type;
                par_bad <= 1'b0;
                bit_cnt <= '0;
            end
            if (state == DATA && bit_ready) shift <= {bit_val, shift[width-1:1]};
            if (state == DATA && bit_end) bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            if (state == PARITY && bit_ready) par_bad <= bit_val != (par_odd ? ~^shift : ^shift);
        end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized scoreboard bench for uart_rx against a frame-level reference model
module tb_uart_rx;
    import uart_pkg::*;
    typedef struct {
        logic       dv, pe, se;
        logic [7:0] data;
    } exp_t;
    logic       CLK = 1'b0;
    logic       Reset = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       Parity_EN = 1'b0;
    logic       Parity_type = 1'b0;
    logic [7:0] P_DATA;
    logic       Data_valid, Parity_error, Stop_error;
    exp_t       q[$];
    logic [7:0] last_good = 8'h00;
    int         n_chk = 0;
    int         n_fail = 0;

    uart_rx #(.width(8)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .RX_IN        (RX_IN),
        .Prescale     (Prescale),
        .Parity_EN    (Parity_EN),
        .Parity_type  (Parity_type),
        .P_DATA       (P_DATA),
        .Data_valid   (Data_valid),
        .Parity_error (Parity_error),
        .Stop_error   (Stop_error)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ideal_parity(input logic [7:0] d, input logic odd);
        return logic'(($countones(d) + int'(odd)) % 2);
    endfunction

    // frame = start, 8 data LSB first, optional parity, stop; each bit held p cycles
    task automatic send(input logic [7:0] d, input logic pen, input logic pt, input logic pbit,
                        input logic stop, input logic [5:0] p, input int cut, input bit track);
        logic [10:0] f;
        int          nb;
        exp_t        e;
        if (track) begin
            e.pe = pen && (pbit != ideal_parity(d, pt));
            e.se = !stop;
            e.dv = !e.pe && !e.se;
            if (e.dv) last_good = d;
            e.data = last_good;
            q.push_back(e);
        end
        f = '0;
        f[8:1] = d;
        if (pen) begin
            f[9]  = pbit;
            f[10] = stop;
        end else f[9] = stop;
        nb = pen ? 11 : 10;
        if (cut > 0 && cut < nb) nb = cut;
        Prescale    = p;
        Parity_EN   = pen;
        Parity_type = pt;
        for (int i = 0; i < nb; i++) begin
            RX_IN = f[i];
            repeat (int'(p)) @(posedge CLK);
            #1;
        end
        RX_IN = 1'b1;
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (Data_valid || Parity_error || Stop_error) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got dv=%0b pe=%0b se=%0b, expected none",
                             Data_valid, Parity_error, Stop_error);
                end else begin
                    e = q.pop_front();
                    chk("data_valid", 32'(Data_valid), 32'(e.dv));
                    chk("parity_error", 32'(Parity_error), 32'(e.pe));
                    chk("stop_error", 32'(Stop_error), 32'(e.se));
                    chk("p_data", 32'(P_DATA), 32'(e.data));
                end
            end
        end
    end

    initial begin
        logic [7:0] d;
        logic [5:0] p;
        logic       pen, pt, pbit, stop;
        int         w;
        #1;
        chk("reset_p_data", 32'(P_DATA), 32'h0);
        chk("reset_pulses", {29'd0, Data_valid, Parity_error, Stop_error}, 32'h0);
        repeat (3) @(posedge CLK);
        #1;
        Reset = 1'b1;
        idle(4);
        send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, PRESCALE_8, 0, 1'b1);
        idle(16);
        send(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, PRESCALE_16, 0, 1'b1);
        send(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, PRESCALE_16, 0, 1'b1);
        idle(8);
        send(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, PRESCALE_32, 0, 1'b1);
        idle(40);
        send(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, PRESCALE_32, 0, 1'b1);
        idle(5);
        Prescale  = PRESCALE_16;
        Parity_EN = 1'b0;
        RX_IN     = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        idle(8);
        send(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, PRESCALE_16, 0, 1'b1);
        send(8'h00, 1'b1, 1'b1, 1'b1, 1'b1, PRESCALE_8, 0, 1'b1);
        send(8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, PRESCALE_8, 0, 1'b1);
        send(8'h96, 1'b1, 1'b1, 1'b1, 1'b1, PRESCALE_8, 0, 1'b1);
        idle(10);
        send(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, PRESCALE_16, 4, 1'b0);
        Reset = 1'b0;
        #1;
        chk("midframe_reset_p_data", 32'(P_DATA), 32'h0);
        chk("midframe_reset_pulses", {29'd0, Data_valid, Parity_error, Stop_error}, 32'h0);
        last_good = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        Reset = 1'b1;
        idle(20);
        chk("post_reset_p_data", 32'(P_DATA), 32'h0);
        send(8'h34, 1'b0, 1'b0, 1'b0, 1'b1, PRESCALE_16, 0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            d    = 8'($urandom);
            w    = int'($urandom_range(0, 2));
            p    = w == 0 ? PRESCALE_8 : w == 1 ? PRESCALE_16 : PRESCALE_32;
            pen  = 1'($urandom);
            pt   = 1'($urandom);
            pbit = ideal_parity(d, pt) ^ ($urandom_range(0, 4) == 0);
            stop = $urandom_range(0, 6) != 0;
            send(d, pen, pt, pbit, stop, p, 0, 1'b1);
            if (!stop || $urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 3)) * int'(p));
        end
        w = 0;
        while (q.size() > 0 && w < 2000) begin
            @(posedge CLK);
            w++;
        end
        idle(20);
        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: width, default 8, number of data bits per frame.
REQ-002 Port: CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: Reset  input  1  asynchronous, active-low reset.
REQ-004 Port: RX_IN  input  1  serial line; idle high; LSB-first frames.
REQ-005 Port: Prescale  input  6  oversampling ratio (CLK cycles per bit); legal values 8, 16, 32.
REQ-006 Port: Parity_EN  input  1  1 = frame carries a parity bit between the data bits and the stop bit.
REQ-007 Port: Parity_type  input  1  0 = even (parity bit = XOR of data), 1 = odd (parity bit = XNOR of data).
REQ-008 Port: P_DATA  output  width  last received data word, registered.
REQ-009 Port: Data_valid  output  1  one-cycle pulse: P_DATA updated with an error-free frame.
REQ-010 Port: Parity_error  output  1  one-cycle pulse: parity mismatch in the frame just ended.
REQ-011 Port: Stop_error  output  1  one-cycle pulse: stop bit sampled low in the frame just ended.

Function
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; all outputs registered.
REQ-013 IDLE: a cycle with RX_IN=0 SHALL be edge 0 of the start bit -> START; Prescale, Parity_EN and Parity_type SHALL be latched on that cycle and used for the whole frame.
REQ-014 Edge counter SHALL count 0..P-1 within each bit (P = latched Prescale) and wrap to 0, advancing the bit counter on wrap.
REQ-015 Each bit SHALL be sampled at edges P/2-1, P/2, P/2+1; bit value = majority of the three, valid from edge P/2+2.
REQ-016 START: a majority value of 1 SHALL abort to IDLE at edge P/2+2 with no output pulse (glitch rejection).
REQ-017 START -> DATA at edge P-1 of a valid start bit.
REQ-018 DATA: width bits SHALL be shifted in LSB first; after edge P-1 of bit width-1 -> PARITY if latched Parity_EN = 1, else STOP.
REQ-019 PARITY: expected bit = Parity_type ? XNOR(data) : XOR(data); mismatch SHALL be recorded for end of frame. -> STOP at edge P-1.
REQ-020 STOP: at edge P-1 SHALL return to IDLE and, in the same cycle, pulse exactly one of: Data_valid (no errors, P_DATA loaded), or Parity_error and/or Stop_error (P_DATA unchanged).
REQ-021 Back-to-back frames: a low RX_IN in the first IDLE cycle after STOP SHALL start a new frame with no lost frame.
REQ-022 RX_IN changes during DATA/PARITY/STOP outside sample edges SHALL have no effect.
REQ-023 Prescale values other than 8/16/32 are unsupported; behaviour undefined but the FSM SHALL always return to IDLE within 2*(width+3)*32 cycles.

Reset
REQ-024 Reset low SHALL immediately force IDLE, counters 0, P_DATA = 0, Data_valid = Parity_error = Stop_error = 0, regardless of frame in progress.
REQ-025 After reset release, reception SHALL resume only on a fresh start bit in IDLE.

Structure
REQ-026 FSM state encoding and the legal Prescale constants SHALL reside in the shared UART package, used by uart_rx and by the transmitter.
REQ-027 One sub-module, uart_rx_sampler (edge counter plus 3-sample majority voter), SHALL be instantiated; the shift register, parity check and FSM SHALL stay in uart_rx.

Verification
REQ-028 Prescale=8, Parity_EN=0, send 0xA5 -> Data_valid one pulse at stop edge 7, P_DATA=0xA5, no error pulses.
REQ-029 Prescale=16, Parity_EN=1, Parity_type=0, send 0x3C with parity 0 then 0x3C with parity 1 -> first: Data_valid, P_DATA=0x3C; second: Parity_error pulse, P_DATA remains 0x3C.
REQ-030 Prescale=32, send 0x81 with stop bit held low -> Stop_error pulse, no Data_valid, then idle line recovers and next frame 0x7E is received correctly.
REQ-031 Prescale=16, RX_IN low for 4 cycles then high -> no pulses, FSM back in IDLE by cycle 10; following valid frame 0x55 received.
REQ-032 Prescale=8, Parity_EN=1, Parity_type=1, three back-to-back frames 0x00, 0xFF, 0x96 -> three Data_valid pulses, correct P_DATA each, no errors.
REQ-033 Assert Reset mid-DATA of frame 0x12 -> outputs 0 immediately; no pulse for that frame; next frame 0x34 gives Data_valid, P_DATA=0x34.
